// File: rtl/pcie_dma_pkg.sv
// Shared types and helpers for the PCIe DMA read-side stream logic.
// Holds the burst reader FSM states and the byte-size arithmetic for one beat.
package pcie_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int BYTES_PER_BEAT = 16;

    // Byte distance covered by a burst of the given beat count
    function automatic logic [63:0] burst_bytes(input logic [31:0] beats);
        return 64'(beats) * 64'(BYTES_PER_BEAT);
    endfunction

endpackage

// File: rtl/pcie_rd_skid_buf.sv
// Two-entry data buffer between the FIFO read port and the outgoing stream.
// Carries data only; burst framing is tracked by the parent.
module pcie_rd_skid_buf
    import pcie_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [1:0]            count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Storage and pointers; the parent never pushes into a full buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == 2'd0);

endmodule

// File: rtl/pcie_fifo_burst_reader.sv
// Drains the async FIFO read side into fixed-length addressed bursts for the
// PCIe DMA write engine; addresses walk linearly through one frame buffer.
module pcie_fifo_burst_reader
    import pcie_dma_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    LEVEL_WIDTH = 10,
    parameter int                    BURST_LEN   = 16,
    parameter int                    FRAME_BEATS = 115200,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   m_valid,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int FR_W = $clog2(FRAME_BEATS + 1);
    localparam int BL_W = $clog2(BURST_LEN + 1);

    state_t                state;
    state_t                state_next;
    logic [FR_W-1:0]       frame_rem;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BL_W-1:0]       rd_cnt;
    logic [BL_W-1:0]       wr_cnt;
    logic [BL_W-1:0]       burst_len_q;
    logic [BL_W-1:0]       cur_len;
    logic                  rd_pend;
    logic                  frame_done_q;
    logic [1:0]            skid_count;
    logic                  skid_empty;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  pop;
    logic                  eop_accept;
    logic                  last_burst;
    logic                  level_ok;
    logic [2:0]            occupancy;
    logic [63:0]           burst_inc;

    // The final burst of a frame shrinks to whatever beats remain
    always_comb begin
        cur_len = BL_W'(BURST_LEN);
        if (32'(frame_rem) < 32'(BURST_LEN)) begin
            cur_len = BL_W'(frame_rem);
        end
    end

    assign level_ok   = (32'(fifo_rd_water_level) >= 32'(cur_len));
    assign pop        = m_valid && m_ready;
    assign eop_accept = pop && (wr_cnt == BL_W'(1));
    assign last_burst = (32'(frame_rem) == 32'(burst_len_q));
    assign burst_inc  = burst_bytes(32'(burst_len_q));

    // Counts the beat leaving this cycle as free space, so a steady accept
    // stream keeps one read issued per cycle without overrunning two entries
    assign occupancy  = {1'b0, skid_count} + {2'b00, rd_pend} - {2'b00, pop};

    // Gated by rst_n so a reset cycle never pulls a word that would be dropped
    assign fifo_rd_en = rst_n && (state == BURST) && (rd_cnt != '0)
                        && !fifo_rd_empty && (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (level_ok) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (eop_accept) begin
                    state_next = last_burst ? IDLE : WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame position: remaining beats and byte address of the current burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_rem <= '0;
            addr      <= '0;
        end else if (state == IDLE && frame_start) begin
            frame_rem <= FR_W'(FRAME_BEATS);
            addr      <= BASE_ADDR;
        end else if (state == BURST && eop_accept) begin
            frame_rem <= frame_rem - FR_W'(burst_len_q);
            addr      <= addr + burst_inc[ADDR_WIDTH-1:0];
        end
    end

    // Per-burst read and write beat counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_len_q <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
        end else if (state == WAIT && level_ok) begin
            burst_len_q <= cur_len;
            rd_cnt      <= cur_len;
            wr_cnt      <= cur_len;
        end else if (state == BURST) begin
            if (fifo_rd_en) begin
                rd_cnt <= rd_cnt - BL_W'(1);
            end
            if (pop) begin
                wr_cnt <= wr_cnt - BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_pend      <= fifo_rd_en;
            frame_done_q <= eop_accept && last_burst;
        end
    end

    pcie_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .pop_data  (skid_data),
        .count     (skid_count),
        .empty     (skid_empty)
    );

    assign m_valid    = !skid_empty;
    assign m_data     = skid_data;
    assign m_sop      = m_valid && (wr_cnt == burst_len_q);
    assign m_eop      = m_valid && (wr_cnt == BL_W'(1));
    assign m_addr     = addr;
    assign busy       = (state != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pcie_fifo_burst_reader.sv
// Scoreboard bench for the burst reader: a 40-beat frame instance for bursts,
// stalls and reset, plus a 1-beat frame instance for the sop=eop corner.
module tb_pcie_fifo_burst_reader;

    localparam int DW = 128;
    localparam int LW = 10;
    localparam int BL = 16;
    localparam int FB = 40;
    localparam int AW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_water_level;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;
    logic [AW-1:0] m_addr;
    logic          m_ready;
    logic          busy;
    logic          frame_done;

    logic          frame_start_b;
    logic          rd_en_b;
    logic [DW-1:0] rd_data_b = '0;
    logic          empty_b;
    logic [LW-1:0] level_b;
    logic          m_valid_b;
    logic [DW-1:0] m_data_b;
    logic          m_sop_b;
    logic          m_eop_b;
    logic [AW-1:0] m_addr_b;
    logic          m_ready_b;
    logic          busy_b;
    logic          frame_done_b;

    int    checks = 0;
    int    failures = 0;
    int    rd_idx = 0;
    int    pushed = 0;
    int    rd_b = 0;
    int    pushed_b = 0;
    int    accept_cnt = 0;
    int    done_cnt = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    pcie_fifo_burst_reader #(
        .DATA_WIDTH (DW), .LEVEL_WIDTH (LW), .BURST_LEN (BL),
        .FRAME_BEATS (FB), .ADDR_WIDTH (AW), .BASE_ADDR (32'h0000_0000)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .frame_start (frame_start),
        .fifo_rd_en (fifo_rd_en), .fifo_rd_data (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty), .fifo_rd_water_level (fifo_rd_water_level),
        .m_valid (m_valid), .m_data (m_data), .m_sop (m_sop), .m_eop (m_eop),
        .m_addr (m_addr), .m_ready (m_ready), .busy (busy), .frame_done (frame_done)
    );

    pcie_fifo_burst_reader #(
        .DATA_WIDTH (DW), .LEVEL_WIDTH (LW), .BURST_LEN (BL),
        .FRAME_BEATS (1), .ADDR_WIDTH (AW), .BASE_ADDR (32'h0000_0000)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .frame_start (frame_start_b),
        .fifo_rd_en (rd_en_b), .fifo_rd_data (rd_data_b),
        .fifo_rd_empty (empty_b), .fifo_rd_water_level (level_b),
        .m_valid (m_valid_b), .m_data (m_data_b), .m_sop (m_sop_b), .m_eop (m_eop_b),
        .m_addr (m_addr_b), .m_ready (m_ready_b), .busy (busy_b), .frame_done (frame_done_b)
    );

    function automatic logic [DW-1:0] pat(input int idx);
        logic [31:0] v;
        v = idx;
        return {v ^ 32'hA5A5_0000, ~v, v + 32'd7, 32'hFEED_0000 | v};
    endfunction

    // FIFO models: data appears one cycle after the read enable
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= pat(rd_idx);
            rd_idx       <= rd_idx + 1;
        end
        if (rd_en_b) begin
            rd_data_b <= pat(1000 + rd_b);
            rd_b      <= rd_b + 1;
        end
    end

    assign fifo_rd_water_level = LW'(pushed - rd_idx);
    assign fifo_rd_empty       = (pushed == rd_idx);
    assign level_b             = LW'(pushed_b - rd_b);
    assign empty_b             = (pushed_b == rd_b);

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Queue the expected beats of a whole frame, then pulse frame_start
    task automatic applyStimulus(input int nbeats);
        beat_t e;
        int    base;
        int    bstart;
        int    blen;
        base = rd_idx;
        for (int k = 0; k < nbeats; k++) begin
            bstart = (k / BL) * BL;
            blen   = (nbeats - bstart < BL) ? (nbeats - bstart) : BL;
            e.data = pat(base + k);
            e.sop  = (k == bstart);
            e.eop  = (k == bstart + blen - 1);
            e.addr = 32'(bstart * 16);
            e.last = (k == nbeats - 1);
            exp_q.push_back(e);
        end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int start;
        bit seen;
        start = done_cnt;
        seen  = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_cnt != start) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: frame_done got none expected one within 3000 cycles", name);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_m_valid"}, m_valid, 0);
        checkOutput({tag, "_rd_en"}, fifo_rd_en, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_sop_eop"}, {m_sop, m_eop}, 0);
        checkOutput({tag, "_m_addr"}, m_addr, 0);
        checkOutput({tag, "_m_data"}, m_data, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability
    beat_t         e_mon;
    logic          prev_stall = 1'b0;
    logic          expect_done = 1'b0;
    logic [DW-1:0] h_data;
    logic [AW+1:0] h_ctl;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                checkOutput("frame_done_pulse", frame_done, 1);
                expect_done = 1'b0;
                done_cnt++;
            end else begin
                checkOutput("frame_done_quiet", frame_done, 0);
            end
            if (prev_stall) begin
                checkOutput("stall_valid", m_valid, 1);
                checkOutput("stall_data", m_data, h_data);
                checkOutput("stall_ctl", {m_sop, m_eop, m_addr}, h_ctl);
            end
            if (m_valid && m_ready) begin
                accept_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat: got data %0h expected no beat", m_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    checkOutput("beat_data", m_data, e_mon.data);
                    checkOutput("beat_sop", m_sop, e_mon.sop);
                    checkOutput("beat_eop", m_eop, e_mon.eop);
                    if (e_mon.sop) checkOutput("beat_addr", m_addr, e_mon.addr);
                    if (e_mon.last) expect_done = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            h_data     = m_data;
            h_ctl      = {m_sop, m_eop, m_addr};
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  base;
        int  start_acc;
        bit  reached;
        rst_n         = 1'b0;
        frame_start   = 1'b0;
        frame_start_b = 1'b0;
        m_ready       = 1'b0;
        m_ready_b     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] frame with 16/16/8 bursts, level preloaded");
        pushed  += 40;
        m_ready  = 1'b1;
        applyStimulus(40);
        waitDone("frame1");
        checkOutput("busy_after_frame1", busy, 0);

        $display("[TB] short last burst waits for level >= 8");
        base    = rd_idx;
        pushed += 32;
        applyStimulus(40);
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk); #1;
            if (rd_idx == base + 32 && !m_valid) reached = 1;
        end
        checkOutput("two_bursts_drained", reached, 1);
        pushed += 7;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("level7_no_rd_en", fifo_rd_en, 0);
            checkOutput("level7_no_valid", m_valid, 0);
        end
        checkOutput("level7_busy", busy, 1);
        pushed += 1;
        waitDone("frame2");

        $display("[TB] level 15 blocks a 16-beat burst");
        pushed += 15;
        applyStimulus(40);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("level15_no_rd_en", fifo_rd_en, 0);
            checkOutput("level15_no_valid", m_valid, 0);
        end
        pushed += 1;
        checkOutput("lat_rd_en_n", fifo_rd_en, 0);
        @(posedge clk); #1;
        checkOutput("lat_rd_en_n1", fifo_rd_en, 1);
        checkOutput("lat_valid_n1", m_valid, 0);
        @(posedge clk); #1;
        checkOutput("lat_valid_n2", m_valid, 0);
        @(posedge clk); #1;
        checkOutput("lat_valid_n3", m_valid, 1);
        pushed += 24;
        waitDone("frame3");

        $display("[TB] random downstream backpressure");
        base    = rd_idx;
        pushed += 20;
        applyStimulus(40);
        start_acc = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == start_acc; i++) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            if (i == 30) pushed += 20;
        end
        checkOutput("random_frame_done", done_cnt != start_acc, 1);
        checkOutput("random_total_reads", 32'(rd_idx - base), 40);
        m_ready = 1'b1;

        $display("[TB] reset mid-burst, restart, ignored frame_start");
        pushed   += 40;
        start_acc = accept_cnt;
        applyStimulus(40);
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk); #1;
            if (accept_cnt >= start_acc + 7) reached = 1;
        end
        checkOutput("seven_beats_before_reset", reached, 1);
        rst_n   = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkIdleOutputs("midreset");
        pushed += 40;
        m_ready = 1'b1;
        applyStimulus(40);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_in_burst", busy, 1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        waitDone("frame_after_reset");

        $display("[TB] one-beat frame");
        pushed_b     += 1;
        m_ready_b     = 1'b1;
        frame_start_b = 1'b1;
        @(posedge clk); #1;
        frame_start_b = 1'b0;
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(posedge clk); #1;
            if (m_valid_b) reached = 1;
        end
        checkOutput("b_valid_seen", reached, 1);
        checkOutput("b_data", m_data_b, pat(1000));
        checkOutput("b_sop_eop", {m_sop_b, m_eop_b}, 2'b11);
        checkOutput("b_addr", m_addr_b, 0);
        @(posedge clk); #1;
        checkOutput("b_frame_done", frame_done_b, 1);
        checkOutput("b_valid_after", m_valid_b, 0);
        @(posedge clk); #1;
        checkOutput("b_frame_done_single", frame_done_b, 0);
        checkOutput("b_busy_after", busy_b, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
